// File: rtl/spi_reg_initiator_if.sv
// Register-bank access port driven by the SPI front-end.
// wr is a single-cycle strobe and address/data_in are valid while it is high.
// There is no ready signal because the bank accepts every strobe.
// data_out is combinational from address.
interface spi_reg_initiator_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              wr;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output wr, output address, output data_in, input data_out);
  modport slave  (input wr, input address, input data_in, output data_out);
endinterface

// File: rtl/spi_reg_initiator.sv
// SPI mode-0 slave that turns {rw, address, data} frames into register-bank
// reads and writes. All SPI pins are oversampled on clk.
module spi_reg_initiator #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       miso_oe,
  output logic       busy,
  output logic       frame_err,
  output logic [2:0] dbg_state_o,
  spi_reg_initiator_if.master bank
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sclk_q, cs_q;
  logic [1:0]        mosi_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              miso_q, miso_d;
  logic              load_tx_q, load_tx_d;
  logic              commit_q, commit_d;
  logic              wr_q, wr_d;
  logic              frame_err_q, frame_err_d;

  // Edges are taken between sync stages 2 and 3; stage 2 is the settled value.
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s, cs_s;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_s      = cs_q[1];
  assign mosi_s    = mosi_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q      <= 3'b000;
      cs_q        <= 3'b111;
      mosi_q      <= 2'b00;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_sh_q   <= '0;
      address_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      data_in_q   <= '0;
      miso_q      <= 1'b0;
      load_tx_q   <= 1'b0;
      commit_q    <= 1'b0;
      wr_q        <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[1:0], spi_sclk};
      cs_q        <= {cs_q[1:0], spi_cs_n};
      mosi_q      <= {mosi_q[0], spi_mosi};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_sh_q   <= addr_sh_d;
      address_q   <= address_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      data_in_q   <= data_in_d;
      miso_q      <= miso_d;
      load_tx_q   <= load_tx_d;
      commit_q    <= commit_d;
      wr_q        <= wr_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_sh_d   = addr_sh_q;
    address_d   = address_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    data_in_d   = data_in_q;
    miso_d      = miso_q;
    load_tx_d   = 1'b0;
    commit_d    = 1'b0;
    wr_d        = 1'b0;
    frame_err_d = 1'b0;

    // The bank read and the write commit run independently of the state, so a CS rise cannot cancel them.
    if (load_tx_q && !rw_q) tx_d = bank.data_out;
    if (commit_q) begin
      wr_d      = 1'b1;
      data_in_d = rx_q;
    end

    unique case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
      end
      S_CMD: begin
        if (cs_rise) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          rw_d    = mosi_s;
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (cs_rise) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          addr_sh_d = {addr_sh_q[ADDR_W-2:0], mosi_s};
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            address_d = addr_sh_d;
            load_tx_d = 1'b1;
            state_d   = S_DATA;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (cs_rise) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (sclk_rise) begin
          rx_d = {rx_q[DATA_W-2:0], mosi_s};
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = S_DONE;
            commit_d = rw_q;
            miso_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sclk_fall && !rw_q) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
      end
      S_DONE: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bank.wr      = wr_q;
  assign bank.address = address_q;
  assign bank.data_in = data_in_q;
  assign busy         = (state_q != S_IDLE);
  assign miso_oe      = ~cs_s;
  assign spi_miso     = miso_q & miso_oe;
  assign frame_err    = frame_err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_spi_reg_initiator.sv
// Directed bench for spi_reg_initiator: bit-banged SPI master plus a 16x32 register bank model.
module tb_spi_reg_initiator;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, miso_oe, busy, frame_err;
  logic [2:0] dbg_state;

  spi_reg_initiator_if #(.ADDR_W(4), .DATA_W(32)) bank_if ();

  spi_reg_initiator #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .miso_oe     (miso_oe),
    .busy        (busy),
    .frame_err   (frame_err),
    .dbg_state_o (dbg_state),
    .bank        (bank_if)
  );

  // clock
  always #5 clk = ~clk;

  // bank model and event counters
  logic [31:0] regs [16] = '{default: 32'h0};
  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = 4'h0;
  logic [31:0] pre_data = 32'h0;
  int          wr_cnt = 0;
  int          ferr_cnt = 0;

  assign bank_if.data_out = regs[bank_if.address];

  always @(posedge clk) begin
    if (pre_en) regs[pre_addr] <= pre_data;
    else if (bank_if.wr) regs[bank_if.address] <= bank_if.data_in;
    if (bank_if.wr) wr_cnt++;
    if (frame_err) ferr_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Drives nbits SCLK cycles. The read word is captured just before each data-phase rise.
  task automatic spi_frame(input logic rw, input logic [3:0] addr, input logic [31:0] data,
                           input int nbits, input bit end_cs,
                           output logic [31:0] rdata, output bit extra_nz);
    logic [36:0] bits;
    bits     = {rw, addr, data};
    rdata    = 32'h0;
    extra_nz = 1'b0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 37) ? bits[36-i] : 1'b0;
      wait_clk(HALF);
      if (i >= 5 && i < 37) rdata = {rdata[30:0], spi_miso};
      if (i >= 37 && spi_miso !== 1'b0) extra_nz = 1'b1;
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
    if (end_cs) begin
      wait_clk(HALF);
      chk("busy_in_frame", {31'h0, busy}, 32'h1);
      chk("oe_in_frame", {31'h0, miso_oe}, 32'h1);
      spi_cs_n = 1'b1;
      wait_clk(8);
    end
  endtask

  logic [31:0] rd;
  bit          xnz;

  initial begin
    // 1: reset with SCLK/MOSI toggling
    for (int i = 0; i < 8; i++) begin
      wait_clk(3);
      spi_sclk = ~spi_sclk;
      spi_mosi = ~spi_mosi;
    end
    chk("rst_wr", {31'h0, bank_if.wr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_miso", {31'h0, spi_miso}, 32'h0);
    chk("rst_oe", {31'h0, miso_oe}, 32'h0);
    chk("rst_addr", {28'h0, bank_if.address}, 32'h0);
    chk("rst_din", bank_if.data_in, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_state", {29'h0, dbg_state}, 32'h0);
    spi_sclk = 1'b0; spi_mosi = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(4);

    // 2: write 0xDEADBEEF to register 5
    spi_frame(1'b1, 4'h5, 32'hDEADBEEF, 37, 1'b1, rd, xnz);
    chk("wr_count", wr_cnt, 32'd1);
    chk("wr_addr", {28'h0, bank_if.address}, 32'h5);
    chk("wr_din", bank_if.data_in, 32'hDEADBEEF);
    chk("wr_reg5", regs[5], 32'hDEADBEEF);
    chk("wr_ferr", ferr_cnt, 32'd0);
    chk("wr_busy_after", {31'h0, busy}, 32'h0);
    chk("wr_oe_after", {31'h0, miso_oe}, 32'h0);

    // 3: read register 9
    preload(4'h9, 32'hA5A5_0F0F);
    spi_frame(1'b0, 4'h9, 32'h0, 37, 1'b1, rd, xnz);
    chk("rd_data", rd, 32'hA5A5_0F0F);
    chk("rd_no_wr", wr_cnt, 32'd1);
    chk("rd_addr", {28'h0, bank_if.address}, 32'h9);

    // 4: abort after 10 data bits, then a full write to the same register
    spi_frame(1'b1, 4'h2, 32'hFFFF_FFFF, 15, 1'b1, rd, xnz);
    chk("ab_ferr", ferr_cnt, 32'd1);
    chk("ab_no_wr", wr_cnt, 32'd1);
    chk("ab_reg2", regs[2], 32'h0);
    chk("ab_addr_kept", {28'h0, bank_if.address}, 32'h2);
    spi_frame(1'b1, 4'h2, 32'h1, 37, 1'b1, rd, xnz);
    chk("ab_rewrite_reg2", regs[2], 32'h1);
    chk("ab_rewrite_wr", wr_cnt, 32'd2);
    chk("ab_rewrite_ferr", ferr_cnt, 32'd1);

    // 5: overrun with 8 extra SCLK cycles
    spi_frame(1'b1, 4'h3, 32'h7, 45, 1'b1, rd, xnz);
    chk("ov_wr", wr_cnt, 32'd3);
    chk("ov_reg3", regs[3], 32'h7);
    chk("ov_ferr", ferr_cnt, 32'd1);
    chk("ov_miso_zero", {31'h0, xnz}, 32'h0);

    // 6: reset in the middle of the data phase
    spi_frame(1'b1, 4'h1, 32'h1234_5678, 15, 1'b0, rd, xnz);
    rst = 1'b0;
    wait_clk(2);
    chk("mr_wr", {31'h0, bank_if.wr}, 32'h0);
    chk("mr_busy", {31'h0, busy}, 32'h0);
    chk("mr_addr", {28'h0, bank_if.address}, 32'h0);
    chk("mr_din", bank_if.data_in, 32'h0);
    chk("mr_oe", {31'h0, miso_oe}, 32'h0);
    spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(8);
    chk("mr_no_wr", wr_cnt, 32'd3);
    chk("mr_reg1", regs[1], 32'h0);
    spi_frame(1'b0, 4'h1, 32'h0, 37, 1'b1, rd, xnz);
    chk("mr_read1", rd, 32'h0);
    chk("mr_read_no_wr", wr_cnt, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
